cms_trace_stream_packer: RTL and testbench
==========================================

Name: cms_trace_stream_packer

Overview:
- Parametrised successor to the continuous monitoring trace path.
- Accumulates a configurable number of performance-event counters with a selectable wrap or saturate mode, together with a clock-cycle delta.
- On each valid retired instruction, snapshots {counters, pc, clk delta, instr, drop flag} into an internal FIFO and streams it out as an AXI-Stream master with a programmable tlast interval.
- On FIFO overflow, does not lose event counts: they fold into the next accepted packet, and the loss is flagged and counted.

Parameters:
- XLEN, 64, pc width.
- NO_OF_PERFORMANCE_EVENTS, 39, number of event inputs / counters.
- PERF_CNT_WIDTH, 7, width of each event counter.
- CLK_DELTA_WIDTH, 16, width of the cycle-delta field.
- FIFO_DEPTH, 8, packet buffer entries; power of 2, at least 2.
- AXI_DATA_WIDTH, 512, tdata width. Elaboration error if NO_OF_PERFORMANCE_EVENTS*PERF_CNT_WIDTH + XLEN + CLK_DELTA_WIDTH + 33 > AXI_DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  accumulate/capture enable
- pc  in  XLEN  retired pc
- instr  in  32  retired instruction
- pc_valid  in  1  pc/instr valid this cycle
- performance_events  in  NO_OF_PERFORMANCE_EVENTS  per-cycle event bitmap
- sat_mode  in  1  1 = counters saturate, 0 = counters wrap
- tlast_interval  in  32  beats per tlast
- M_AXIS_tvalid  out  1
- M_AXIS_tready  in  1
- M_AXIS_tdata  out  AXI_DATA_WIDTH
- M_AXIS_tlast  out  1
- drop_count  out  32  packets dropped since reset; saturates at 0xFFFFFFFF
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync deassert internal): all counters, clk delta, FIFO pointers, beat counter, drop_count and the pending-drop flag go to 0. Outputs M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0, fifo_level=0.
- Event accumulation, each cycle with en=1:
  - next_cnt[i] = cnt[i] + performance_events[i].
  - In wrap mode the sum is mod 2^PERF_CNT_WIDTH.
  - In sat mode the sum holds at all-ones.
- Clock delta, each cycle with en=1: next_delta = delta + 1, same wrap/saturate rule as the event counters. With en=0, nothing changes and no capture occurs.
- Capture fires when en & pc_valid.
  - If FIFO not full: push a packet built from the next_cnt/next_delta values, so the current cycle's events are included.
    - Packet layout, LSB first: counters[i] at i*PERF_CNT_WIDTH; pc at N*CW; delta at N*CW+XLEN; instr after delta; drop flag in the next bit; all remaining bits 0.
    - After the push, cnt and delta load 0 and the pending-drop flag clears.
  - If FIFO full: no push, even if a pop happens the same cycle (deterministic drop rule).
    - cnt and delta still take their next_ values (counts carry into the next packet).
    - pending-drop flag is set.
    - drop_count increments.
  - Drop flag in a packet = pending-drop flag at the time of push.
- FIFO is first-word-fall-through.
  - M_AXIS_tvalid = !empty.
  - M_AXIS_tdata = head entry when valid, else 0.
  - Capture at cycle N is visible on tdata at N+1.
- Pop occurs on M_AXIS_tvalid & M_AXIS_tready. A push and a pop in the same cycle when not full leave the level unchanged.
- tvalid/tdata are held stable while tready=0.
- tlast:
  - A beat counter counts handshakes.
  - M_AXIS_tlast = tvalid & (beat == max(tlast_interval,1)-1); a tlast_interval of 0 behaves as 1.
  - The beat counter resets to 0 on the tlast handshake.
  - If tlast_interval is lowered below the current beat count, tlast asserts on the next beat and the counter resets.
- Reset mid-stream discards FIFO contents immediately (tvalid drops asynchronously).

Decomposition:
- Additions to continuous_monitoring_system_pkg:
  - Field-offset localparam functions (PC_LOCATION etc. computed from the parameters).
  - A sat_mode enum { CNT_WRAP, CNT_SATURATE }.
- Sub-module cms_stream_fifo: parametrised width/depth, FWFT, full/empty/level outputs.
- Counter, capture and tlast logic stay in the top module.

Test Plan:
- Wrap vs saturate:
  - Stimulus: event[0]=1 every cycle for 130 cycles with no pc_valid, then one pc_valid.
  - Required: sat_mode=0 gives field0=130 mod 128=2; sat_mode=1 gives field0=127; delta field=131 in both.
- Basic capture:
  - Stimulus: pc=0x100, instr=0x0000006f, events=8'b10101010, pc_valid=1 on 3 consecutive cycles.
  - Required: 3 beats; odd counters =1, even counters =0, delta=1 after the first packet; tdata valid one cycle after each capture.
- Overflow:
  - Stimulus: tready=0, FIFO_DEPTH=8, 10 captures with event[1]=1 each cycle.
  - Required: 8 entries, then drop_count=2.
  - Release tready and capture once more: the 9th delivered packet has drop flag=1 and counter[1]=3.
- tlast interval:
  - Stimulus: tlast_interval=3, 7 packets, tready=1.
  - Required: tlast on beats 3 and 6 only.
  - tlast_interval=0: tlast on every beat.
- Backpressure stability:
  - Stimulus: tready toggles 0/1 every cycle over 5 packets.
  - Required: tdata constant while tvalid&!tready; packet order preserved.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 with 4 packets queued.
  - Required: tvalid=0, fifo_level=0, drop_count=0 immediately; first packet after release has delta counted from release.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and packet field-offset helpers for the continuous monitoring trace path.
// Offsets are functions of the parameters so every instance agrees on one packet layout.
package continuous_monitoring_system_pkg;

    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } cnt_mode_e;

    localparam int INSTR_WIDTH = 32;

    function automatic int pc_location(input int n_events, input int cnt_width);
        return n_events * cnt_width;
    endfunction

    function automatic int delta_location(input int n_events, input int cnt_width, input int xlen);
        return pc_location(n_events, cnt_width) + xlen;
    endfunction

    function automatic int instr_location(input int n_events, input int cnt_width, input int xlen,
                                          input int delta_width);
        return delta_location(n_events, cnt_width, xlen) + delta_width;
    endfunction

    function automatic int drop_location(input int n_events, input int cnt_width, input int xlen,
                                         input int delta_width);
        return instr_location(n_events, cnt_width, xlen, delta_width) + INSTR_WIDTH;
    endfunction

    function automatic int packet_width(input int n_events, input int cnt_width, input int xlen,
                                        input int delta_width);
        return drop_location(n_events, cnt_width, xlen, delta_width) + 1;
    endfunction

endpackage

// File: rtl/cms_stream_fifo.sv
// First-word-fall-through packet buffer: head is valid whenever the FIFO is not empty.
// Pointers carry one extra wrap bit so full and empty are distinguished by the level.
module cms_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cms_trace_stream_packer.sv
// Accumulates event counters and a cycle delta, snapshots them with pc/instr on each retired
// instruction, and streams the packets out through a FWFT FIFO as an AXI-Stream master.
module cms_trace_stream_packer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int XLEN                     = 64,
    parameter int NO_OF_PERFORMANCE_EVENTS = 39,
    parameter int PERF_CNT_WIDTH           = 7,
    parameter int CLK_DELTA_WIDTH          = 16,
    parameter int FIFO_DEPTH               = 8,
    parameter int AXI_DATA_WIDTH           = 512
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic [XLEN-1:0]                     pc,
    input  logic [31:0]                         instr,
    input  logic                                pc_valid,
    input  logic [NO_OF_PERFORMANCE_EVENTS-1:0] performance_events,
    input  logic                                sat_mode,
    input  logic [31:0]                         tlast_interval,
    output logic                                M_AXIS_tvalid,
    input  logic                                M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0]           M_AXIS_tdata,
    output logic                                M_AXIS_tlast,
    output logic [31:0]                         drop_count,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

    localparam int N         = NO_OF_PERFORMANCE_EVENTS;
    localparam int CW        = PERF_CNT_WIDTH;
    localparam int DW        = CLK_DELTA_WIDTH;
    localparam int PC_LOC    = pc_location(N, CW);
    localparam int DELTA_LOC = delta_location(N, CW, XLEN);
    localparam int INSTR_LOC = instr_location(N, CW, XLEN, DW);
    localparam int DROP_LOC  = drop_location(N, CW, XLEN, DW);
    localparam int PKT_W     = packet_width(N, CW, XLEN, DW);

    if (PKT_W > AXI_DATA_WIDTH) begin : g_width_check
        $error("cms_trace_stream_packer: packet of %0d bits exceeds AXI_DATA_WIDTH", PKT_W);
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("cms_trace_stream_packer: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [CW-1:0]    cnt      [N];
    logic [CW-1:0]    next_cnt [N];
    logic [DW-1:0]    delta;
    logic [DW-1:0]    next_delta;
    logic             saturate;
    logic             pending_drop;
    logic             capture;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             drop;
    logic             pop;
    logic [PKT_W-1:0] pkt;
    logic [PKT_W-1:0] head;
    logic [31:0]      beat;
    logic [31:0]      beat_lim;
    logic             beat_at_last;

    assign saturate = (cnt_mode_e'(sat_mode) == CNT_SATURATE);
    assign capture  = en & pc_valid;
    assign push     = capture & ~fifo_full;
    // A full FIFO drops even if a pop frees a slot this cycle, so drops never depend on tready.
    assign drop     = capture & fifo_full;
    assign pop      = M_AXIS_tvalid & M_AXIS_tready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (saturate && (&cnt[i])) next_cnt[i] = cnt[i];
            else                       next_cnt[i] = cnt[i] + CW'(performance_events[i]);
        end
        if (saturate && (&delta)) next_delta = delta;
        else                      next_delta = delta + 1'b1;
    end

    always_comb begin
        pkt = '0;
        for (int i = 0; i < N; i++) begin
            pkt[i*CW +: CW] = next_cnt[i];
        end
        pkt[PC_LOC +: XLEN]           = pc;
        pkt[DELTA_LOC +: DW]          = next_delta;
        pkt[INSTR_LOC +: INSTR_WIDTH] = instr;
        pkt[DROP_LOC]                 = pending_drop;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            delta        <= '0;
            pending_drop <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (en) begin
                for (int i = 0; i < N; i++) cnt[i] <= push ? '0 : next_cnt[i];
                delta <= push ? '0 : next_delta;
            end
            if (push)      pending_drop <= 1'b0;
            else if (drop) pending_drop <= 1'b1;
            if (drop && drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
        end
    end

    cms_stream_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (push),
        .push_data (pkt),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign M_AXIS_tvalid = ~fifo_empty;
    assign M_AXIS_tdata  = fifo_empty ? '0 : AXI_DATA_WIDTH'(head);

    // Comparing with >= lets a lowered interval end the current burst on the next beat.
    assign beat_lim      = (tlast_interval == 32'd0) ? 32'd0 : tlast_interval - 32'd1;
    assign beat_at_last  = (beat >= beat_lim);
    assign M_AXIS_tlast  = M_AXIS_tvalid & beat_at_last;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            beat <= '0;
        end else if (pop) begin
            beat <= beat_at_last ? 32'd0 : beat + 32'd1;
        end
    end

endmodule

// File: tb/tb_cms_trace_stream_packer.sv
// Randomised and directed bench for cms_trace_stream_packer with a queue-based scoreboard
// fed by an arithmetic reference model of counters, drops and FIFO occupancy.
module tb_cms_trace_stream_packer;

    localparam int XLEN      = 64;
    localparam int N         = 39;
    localparam int CW        = 7;
    localparam int DW        = 16;
    localparam int DEPTH     = 8;
    localparam int W         = 512;
    localparam int PC_OFF    = N * CW;
    localparam int DELTA_OFF = PC_OFF + XLEN;
    localparam int INSTR_OFF = DELTA_OFF + DW;
    localparam int DROP_OFF  = INSTR_OFF + 32;
    localparam int CMAX      = (1 << CW) - 1;
    localparam int DMAX      = (1 << DW) - 1;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [XLEN-1:0] pc;
    logic [31:0]    instr;
    logic           pc_valid;
    logic [N-1:0]   events;
    logic           sat_mode;
    logic [31:0]    tlast_interval;
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic           tlast;
    logic [31:0]    drop_count;
    logic [3:0]     fifo_level;

    cms_trace_stream_packer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .en                 (en),
        .pc                 (pc),
        .instr              (instr),
        .pc_valid           (pc_valid),
        .performance_events (events),
        .sat_mode           (sat_mode),
        .tlast_interval     (tlast_interval),
        .M_AXIS_tvalid      (tvalid),
        .M_AXIS_tready      (tready),
        .M_AXIS_tdata       (tdata),
        .M_AXIS_tlast       (tlast),
        .drop_count         (drop_count),
        .fifo_level         (fifo_level)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state and reference model
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_pop = 0;
    int           n_tlast = 0;
    logic [W-1:0] last_pop = '0;
    int           m_cnt[N];
    int           m_delta;
    bit           m_pend;
    int           m_level;
    int           m_drop;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int acc(input int v, input int inc, input int maxv, input bit sat);
        int s;
        s = v + inc;
        if (sat) return (s > maxv) ? maxv : s;
        return s % (maxv + 1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_delta = 0;
        m_pend  = 1'b0;
        m_level = 0;
        m_drop  = 0;
        exp_q.delete();
    endtask

    // Applies the current inputs to the model, then lets one clock edge pass.
    task automatic step();
        int           nc[N];
        int           nd;
        bit           pop_now;
        bit           full_now;
        logic [W-1:0] p;
        pop_now  = (m_level > 0) && tready;
        full_now = (m_level == DEPTH);
        if (en) begin
            for (int i = 0; i < N; i++) nc[i] = acc(m_cnt[i], int'(events[i]), CMAX, sat_mode);
            nd = acc(m_delta, 1, DMAX, sat_mode);
            if (pc_valid && !full_now) begin
                p = '0;
                for (int i = 0; i < N; i++) p[i*CW +: CW] = nc[i][CW-1:0];
                p[PC_OFF +: XLEN]  = pc;
                p[DELTA_OFF +: DW] = nd[DW-1:0];
                p[INSTR_OFF +: 32] = instr;
                p[DROP_OFF]        = m_pend;
                exp_q.push_back(p);
                m_level++;
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                m_delta = 0;
                m_pend  = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
                m_delta = nd;
                if (pc_valid) begin
                    m_pend = 1'b1;
                    m_drop++;
                end
            end
        end
        if (pop_now) m_level--;
        @(posedge clk);
        #1;
        check("fifo_level", W'(fifo_level), W'(m_level));
        check("drop_count", W'(drop_count), W'(m_drop));
    endtask

    task automatic drive(input bit e, input bit v, input logic [N-1:0] ev, input bit rdy);
        en       = e;
        pc_valid = v;
        events   = ev;
        tready   = rdy;
        step();
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) drive(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        pc_valid = 1'b0;
        events   = '0;
        #1;
        check("rst_tvalid", W'(tvalid), '0);
        check("rst_tlast", W'(tlast), '0);
        check("rst_tdata", tdata, '0);
        check("rst_fifo_level", W'(fifo_level), '0);
        check("rst_drop_count", W'(drop_count), '0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        tready = 1'b1;
        idle(4);
    endtask

    // monitor: compares every handshake against the expected queue
    initial begin
        logic         stall;
        logic [W-1:0] stall_data;
        int           mbeat;
        int           iv;
        bit           exp_last;
        logic [W-1:0] exp;
        stall = 1'b0;
        stall_data = '0;
        mbeat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mbeat = 0;
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_tvalid", W'(tvalid), W'(1));
                    check("stall_tdata", tdata, stall_data);
                end
                if (!tvalid) begin
                    check("idle_tdata", tdata, '0);
                    check("idle_tlast", W'(tlast), '0);
                end else begin
                    iv = (tlast_interval == 0) ? 1 : int'(tlast_interval);
                    exp_last = (mbeat + 1 >= iv);
                    check("tlast", W'(tlast), W'(exp_last));
                    if (tready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", tdata, '0);
                        end else begin
                            exp = exp_q.pop_front();
                            check("tdata", tdata, exp);
                        end
                        last_pop = tdata;
                        n_pop++;
                        if (tlast) n_tlast++;
                        mbeat = exp_last ? 0 : mbeat + 1;
                    end
                end
                stall = tvalid & ~tready;
                stall_data = tdata;
            end
        end
    end

    // stimulus
    initial begin
        logic [N-1:0] ev_r;
        rst_n          = 1'b1;
        en             = 1'b0;
        pc             = 64'h1234;
        instr          = 32'h13;
        pc_valid       = 1'b0;
        events         = '0;
        sat_mode       = 1'b0;
        tlast_interval = 32'd1;
        tready         = 1'b1;
        #2;

        // wrap then saturate: 130 event cycles plus one capture cycle
        for (int m = 0; m < 2; m++) begin
            do_reset();
            sat_mode = m[0];
            for (int k = 0; k < 130; k++) drive(1'b1, 1'b0, N'(1), 1'b1);
            drive(1'b1, 1'b1, '0, 1'b1);
            idle(3);
            check(m == 0 ? "wrap_field0" : "sat_field0", W'(last_pop[CW-1:0]),
                  m == 0 ? W'(2) : W'(127));
            check("wrap_sat_delta", W'(last_pop[DELTA_OFF +: DW]), W'(131));
        end

        // basic capture
        do_reset();
        sat_mode = 1'b0;
        pc       = 64'h100;
        instr    = 32'h0000_006f;
        n_pop    = 0;
        drive(1'b1, 1'b1, N'(8'hAA), 1'b1);
        check("capture_latency", W'(tvalid), W'(1));
        drive(1'b1, 1'b1, N'(8'hAA), 1'b1);
        drive(1'b1, 1'b1, N'(8'hAA), 1'b1);
        idle(3);
        check("basic_beats", W'(n_pop), W'(3));
        check("basic_cnt0", W'(last_pop[0 +: CW]), W'(0));
        check("basic_cnt1", W'(last_pop[CW +: CW]), W'(1));
        check("basic_cnt7", W'(last_pop[7*CW +: CW]), W'(1));
        check("basic_delta", W'(last_pop[DELTA_OFF +: DW]), W'(1));
        check("basic_pc", W'(last_pop[PC_OFF +: XLEN]), W'(64'h100));

        // overflow: 10 captures into a stalled FIFO
        do_reset();
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, N'(2), 1'b0);
        check("ovf_level", W'(fifo_level), W'(8));
        check("ovf_drops", W'(drop_count), W'(2));
        n_pop = 0;
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b1, 1'b1, N'(2), 1'b1);
        idle(12);
        check("ovf_delivered", W'(n_pop), W'(9));
        check("ovf_drop_flag", W'(last_pop[DROP_OFF]), W'(1));
        check("ovf_cnt1", W'(last_pop[CW +: CW]), W'(3));

        // tlast interval 3, then 0
        do_reset();
        tlast_interval = 32'd3;
        n_tlast = 0;
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, N'({$urandom, $urandom}), 1'b1);
        idle(3);
        check("tlast_iv3", W'(n_tlast), W'(2));
        tlast_interval = 32'd0;
        n_tlast = 0;
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, N'({$urandom, $urandom}), 1'b1);
        idle(3);
        check("tlast_iv0", W'(n_tlast), W'(4));

        // backpressure: tready toggles every cycle
        do_reset();
        tlast_interval = 32'd2;
        n_pop = 0;
        for (int k = 0; k < 5; k++) begin
            pc = {$urandom, $urandom};
            drive(1'b1, 1'b1, N'({$urandom, $urandom}), k[0]);
        end
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b0, '0, k[0]);
        check("bp_delivered", W'(n_pop), W'(5));

        // reset with 4 packets queued
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, N'(1), 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, '0, 1'b1);
        drive(1'b1, 1'b1, '0, 1'b1);
        idle(3);
        check("post_reset_delta", W'(last_pop[DELTA_OFF +: DW]), W'(5));

        // randomised traffic
        do_reset();
        tlast_interval = 32'($urandom_range(0, 4));
        for (int k = 0; k < 400; k++) begin
            if (k % 100 == 0) sat_mode = 1'($urandom_range(0, 1));
            pc    = {$urandom, $urandom};
            instr = $urandom;
            ev_r  = N'({$urandom, $urandom});
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, ev_r,
                  $urandom_range(0, 2) != 0);
        end
        for (int k = 0; k < 50 && m_level > 0; k++) idle(1);
        idle(2);
        check("drain_empty", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
